// File: rtl/accel_tick_pkg.sv
// Shared types and helpers for the accelerating tick generator:
// decrement-mode encoding, tick counter width and the period clamp.
package accel_tick_pkg;

    typedef enum logic {
        MODE_LINEAR = 1'b0,
        MODE_GEOM   = 1'b1
    } mode_e;

    localparam int unsigned TICK_CNT_W = 16;

    // Evaluated at 64 bits so any CNT_W up to 64 can pass through unchanged.
    function automatic longint unsigned clamp(input longint unsigned x,
                                              input longint unsigned lo,
                                              input longint unsigned hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

endpackage

// File: rtl/accel_tick_gen_if.sv
// Control/status bundle between the game FSM (master) and the tick
// generator (slave).
interface accel_tick_gen_if
    import accel_tick_pkg::*;
#(
    parameter int unsigned CNT_W = 28
);
    logic                  en;
    logic                  restart;
    mode_e                 mode;
    logic                  load;
    logic [CNT_W-1:0]      load_period;
    logic                  tick;
    logic                  level;
    logic [CNT_W-1:0]      period_cur;
    logic                  at_min;
    logic [TICK_CNT_W-1:0] tick_cnt;

    modport master (
        output en, restart, mode, load, load_period,
        input  tick, level, period_cur, at_min, tick_cnt
    );

    modport slave (
        input  en, restart, mode, load, load_period,
        output tick, level, period_cur, at_min, tick_cnt
    );
endinterface

// File: rtl/accel_period_step.sv
// Next-period calculator: linear (fixed STEP) or geometric (period>>SHIFT,
// minimum 1) decrement, floored at MIN_PERIOD.
module accel_period_step
    import accel_tick_pkg::*;
#(
    parameter int unsigned CNT_W      = 28,
    parameter int unsigned MIN_PERIOD = 5000000,
    parameter int unsigned STEP       = 50000,
    parameter int unsigned SHIFT      = 5
) (
    input  logic [CNT_W-1:0] period_cur,
    input  mode_e            mode,
    output logic [CNT_W-1:0] next_period
);
    localparam int unsigned      EW     = CNT_W + 1;
    localparam logic [EW-1:0]    MIN_E  = EW'(MIN_PERIOD);
    localparam logic [EW-1:0]    STEP_E = EW'(STEP);
    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_PERIOD);

    logic [CNT_W-1:0] dec_geom;
    logic [EW-1:0]    dec_e;

    // Compare p >= MIN + dec in one extra bit instead of subtracting first,
    // so neither side can wrap.
    always_comb begin
        dec_geom = period_cur >> SHIFT;
        if (dec_geom == '0) dec_geom = CNT_W'(1);
        dec_e = (mode == MODE_GEOM) ? {1'b0, dec_geom} : STEP_E;
        if ({1'b0, period_cur} >= MIN_E + dec_e)
            next_period = period_cur - dec_e[CNT_W-1:0];
        else
            next_period = MIN_C;
    end
endmodule

// File: rtl/accel_tick_gen.sv
// Accelerating tick generator: 1-cycle tick every period_cur cycles, period
// shrinking per tick to a floor. Optional tick counter: ACCEL_TICK_CNT_EN.
module accel_tick_gen
    import accel_tick_pkg::*;
#(
    parameter int unsigned CNT_W       = 28,
    parameter int unsigned INIT_PERIOD = 100000000,
    parameter int unsigned MIN_PERIOD  = 5000000,
    parameter int unsigned MAX_PERIOD  = 200000000,
    parameter int unsigned STEP        = 50000,
    parameter int unsigned SHIFT       = 5
) (
    input  logic            C50,
    input  logic            resetn,
    accel_tick_gen_if.slave bus
);
    localparam logic [CNT_W-1:0] INIT_C =
        CNT_W'(clamp(64'(INIT_PERIOD), 64'(MIN_PERIOD), 64'(MAX_PERIOD)));
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PERIOD);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] period_cur;
    logic [CNT_W-1:0] next_period;
    logic [CNT_W-1:0] load_clamped;
    logic             tick;
    logic             level;
    logic             terminal;

    accel_period_step #(
        .CNT_W      (CNT_W),
        .MIN_PERIOD (MIN_PERIOD),
        .STEP       (STEP),
        .SHIFT      (SHIFT)
    ) u_step (
        .period_cur  (period_cur),
        .mode        (bus.mode),
        .next_period (next_period)
    );

    assign terminal     = (count == period_cur - CNT_W'(1));
    assign load_clamped = CNT_W'(clamp(64'(bus.load_period), 64'(MIN_PERIOD), 64'(MAX_PERIOD)));

    always_ff @(posedge C50) begin
        if (!resetn) begin
            count      <= '0;
            period_cur <= INIT_C;
            tick       <= 1'b0;
            level      <= 1'b0;
        end else if (bus.restart) begin
            count      <= '0;
            period_cur <= INIT_C;
            tick       <= 1'b0;
        end else if (bus.load) begin
            count      <= '0;
            period_cur <= load_clamped;
            tick       <= 1'b0;
        end else if (bus.en) begin
            if (terminal) begin
                count      <= '0;
                period_cur <= next_period;
                tick       <= 1'b1;
                level      <= ~level;
            end else begin
                count <= count + CNT_W'(1);
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

`ifdef ACCEL_TICK_CNT_EN
    logic [TICK_CNT_W-1:0] tick_cnt;
    logic                  fire;

    // Same qualification as the tick itself: restart and load both suppress it.
    assign fire = bus.en && terminal && !bus.restart && !bus.load;

    always_ff @(posedge C50) begin
        if (!resetn || bus.restart)
            tick_cnt <= '0;
        else if (fire)
            tick_cnt <= tick_cnt + TICK_CNT_W'(1);
    end

    assign bus.tick_cnt = tick_cnt;
`else
    assign bus.tick_cnt = '0;
`endif

    assign bus.tick       = tick;
    assign bus.level      = level;
    assign bus.period_cur = period_cur;
    assign bus.at_min     = (period_cur == MIN_C);
endmodule

// File: tb/tb_accel_tick_gen.sv
// Bench for accel_tick_gen: directed pacing scenarios plus random stimulus,
// all checked every cycle against an arithmetic reference model.
module tb_accel_tick_gen;
    import accel_tick_pkg::*;

    localparam int CNT_W_T = 8;
    localparam int INIT_T  = 10;
    localparam int MIN_T   = 4;
    localparam int MAX_T   = 20;
    localparam int STEP_T  = 3;
    localparam int SHIFT_T = 2;
`ifdef ACCEL_TICK_CNT_EN
    localparam bit TC_EN = 1'b1;
`else
    localparam bit TC_EN = 1'b0;
`endif

    logic C50;
    logic resetn;
    int   checks = 0;
    int   errors = 0;

    accel_tick_gen_if #(.CNT_W(CNT_W_T)) bus ();

    accel_tick_gen #(
        .CNT_W       (CNT_W_T),
        .INIT_PERIOD (INIT_T),
        .MIN_PERIOD  (MIN_T),
        .MAX_PERIOD  (MAX_T),
        .STEP        (STEP_T),
        .SHIFT       (SHIFT_T)
    ) dut (
        .C50    (C50),
        .resetn (resetn),
        .bus    (bus)
    );

    initial C50 = 1'b0;
    always #10 C50 = ~C50;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int x);
        if (x < MIN_T) return MIN_T;
        if (x > MAX_T) return MAX_T;
        return x;
    endfunction

    function automatic int nextp(input int p, input bit geom);
        int d;
        d = geom ? p / (1 << SHIFT_T) : STEP_T;
        if (d < 1) d = 1;
        return (p - d < MIN_T) ? MIN_T : p - d;
    endfunction

    // Reference model: count of enabled cycles since the last period start.
    int m_count, m_period, m_tc;
    bit m_tick, m_level, started;

    initial begin
        bit s_rst, s_restart, s_load, s_en, s_geom;
        int s_lp;
        started = 1'b0;
        forever begin
            @(posedge C50);
            s_rst     = resetn;
            s_restart = bus.restart;
            s_load    = bus.load;
            s_lp      = int'(bus.load_period);
            s_en      = bus.en;
            s_geom    = (bus.mode == MODE_GEOM);
            @(negedge C50);
            if (!s_rst) begin
                m_count = 0; m_period = clampi(INIT_T); m_tick = 0;
                m_level = 0; m_tc = 0; started = 1'b1;
            end else if (s_restart) begin
                m_count = 0; m_period = clampi(INIT_T); m_tick = 0; m_tc = 0;
            end else if (s_load) begin
                m_count = 0; m_period = clampi(s_lp); m_tick = 0;
            end else if (s_en) begin
                m_count++;
                m_tick = (m_count == m_period);
                if (m_tick) begin
                    m_count  = 0;
                    m_level  = !m_level;
                    m_tc     = (m_tc + 1) % 65536;
                    m_period = nextp(m_period, s_geom);
                end
            end else begin
                m_tick = 0;
            end
            if (started) begin
                chk("tick", bus.tick, m_tick);
                chk("level", bus.level, m_level);
                chk("period_cur", bus.period_cur, m_period);
                chk("at_min", bus.at_min, m_period == MIN_T);
                chk("tick_cnt", bus.tick_cnt, TC_EN ? m_tc : 0);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge C50);
        #1;
    endtask

    // Negedges until a tick is seen; bounded so a dead DUT cannot hang the run.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge C50);
            n++;
        end while (!bus.tick && n < 200);
    endtask

    task automatic do_reset();
        resetn = 1'b0; bus.en = 1'b0; bus.restart = 1'b0; bus.load = 1'b0;
        cyc(1);
        resetn = 1'b1;
        @(negedge C50);
    endtask

    task automatic pulse_load(input int v);
        bus.load = 1'b1;
        bus.load_period = CNT_W_T'(v);
        cyc(1);
        bus.load = 1'b0;
        @(negedge C50);
    endtask

    int n;
    int geo_gap[7]  = '{16, 12, 9, 7, 6, 5, 4};
    int geo_next[7] = '{12, 9, 7, 6, 5, 4, 4};

    initial begin
        resetn = 1'b1; bus.en = 1'b0; bus.restart = 1'b0; bus.load = 1'b0;
        bus.mode = MODE_LINEAR; bus.load_period = '0;
        cyc(2);

        // Linear acceleration from reset
        do_reset();
        chk("rst_period", bus.period_cur, 10);
        chk("rst_tick", bus.tick, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_at_min", bus.at_min, 0);
        chk("rst_tick_cnt", bus.tick_cnt, 0);
        bus.en = 1'b1;
        wait_tick(n); chk("lin_gap1", n, 10); chk("lin_p1", bus.period_cur, 7); chk("lin_lvl1", bus.level, 1);
        wait_tick(n); chk("lin_gap2", n, 7);  chk("lin_p2", bus.period_cur, 4); chk("lin_min2", bus.at_min, 1);
        chk("lin_lvl2", bus.level, 0);
        wait_tick(n); chk("lin_gap3", n, 4);  chk("lin_p3", bus.period_cur, 4);
        wait_tick(n); chk("lin_gap4", n, 4);
        wait_tick(n); chk("lin_gap5", n, 4);
        chk("lin_tc5", bus.tick_cnt, TC_EN ? 5 : 0);

        // Pause at count 3 for 5 cycles
        do_reset();
        bus.en = 1'b1;
        cyc(3);
        bus.en = 1'b0;
        repeat (5) begin
            @(negedge C50);
            chk("pause_tick", bus.tick, 0);
        end
        bus.en = 1'b1;
        wait_tick(n); chk("pause_gap", n, 7);

        // Geometric mode from period 16, plus load clamping
        do_reset();
        bus.en = 1'b1;
        bus.mode = MODE_GEOM;
        pulse_load(16);
        chk("geo_load", bus.period_cur, 16);
        for (int i = 0; i < 7; i++) begin
            wait_tick(n);
            chk("geo_gap", n, geo_gap[i]);
            chk("geo_next", bus.period_cur, geo_next[i]);
        end
        pulse_load(2);
        chk("load_lo", bus.period_cur, 4); chk("load_lo_tick", bus.tick, 0);
        wait_tick(n); chk("load_lo_gap", n, 4);
        pulse_load(50);
        chk("load_hi", bus.period_cur, 20); chk("load_hi_tick", bus.tick, 0);
        wait_tick(n); chk("load_hi_gap", n, 20);
        bus.mode = MODE_LINEAR;

        // Restart coincident with terminal count (period 7, count 6)
        do_reset();
        bus.en = 1'b1;
        wait_tick(n);
        cyc(6);
        bus.restart = 1'b1;
        cyc(1);
        bus.restart = 1'b0;
        @(negedge C50);
        chk("rs_tick", bus.tick, 0); chk("rs_period", bus.period_cur, 10);
        chk("rs_level", bus.level, 1); chk("rs_tc", bus.tick_cnt, 0);
        wait_tick(n); chk("rs_gap", n, 10);

        // Reset mid-period at count 6
        do_reset();
        bus.en = 1'b1;
        wait_tick(n);
        cyc(6);
        resetn = 1'b0;
        cyc(1);
        resetn = 1'b1;
        @(negedge C50);
        chk("mr_period", bus.period_cur, 10); chk("mr_level", bus.level, 0);
        chk("mr_tick", bus.tick, 0); chk("mr_tc", bus.tick_cnt, 0);
        wait_tick(n); chk("mr_gap", n, 10);

        // Random stimulus
        repeat (4000) begin
            cyc(1);
            resetn          = ($urandom_range(0, 299) != 0);
            bus.en          = ($urandom_range(0, 7) != 0);
            bus.restart     = ($urandom_range(0, 63) == 0);
            bus.load        = ($urandom_range(0, 47) == 0);
            bus.load_period = CNT_W_T'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0)
                bus.mode = ($urandom_range(0, 1) != 0) ? MODE_GEOM : MODE_LINEAR;
        end
        @(negedge C50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
